// File: rtl/sm_div_seq_if.sv
// sm_div_seq_if: start/busy/done handshake plus operand and result bus of the
// sign-magnitude sequential divider. The controller side uses the master
// modport and the divider uses the slave modport.
interface sm_div_seq_if #(
  parameter int DW_MAG = 4,
  parameter int DV_MAG = 2
);
  // Request side
  logic              i_start;
  logic [DW_MAG:0]   i_A;
  logic [DV_MAG:0]   i_B;

  // Status and result side
  logic              o_busy;
  logic              o_done;
  logic [DW_MAG:0]   o_Q;
  logic [DV_MAG:0]   o_R;
  logic              o_Z;
  logic              o_DZ;

  modport master (
    output i_start,
    output i_A,
    output i_B,
    input  o_busy,
    input  o_done,
    input  o_Q,
    input  o_R,
    input  o_Z,
    input  o_DZ
  );

  modport slave (
    input  i_start,
    input  i_A,
    input  i_B,
    output o_busy,
    output o_done,
    output o_Q,
    output o_R,
    output o_Z,
    output o_DZ
  );
endinterface

// File: rtl/sm_div_seq.sv
// sm_div_seq: sequential sign-magnitude restoring divider.
// Dividend is DW_MAG+1 bits (sign + magnitude), divisor DV_MAG+1 bits.
// One quotient bit is produced per CALC cycle, MSB first.
// Optional feature macro: SM_DIV_EARLY_ZERO_EN -- when defined, a zero
// dividend magnitude with a non-zero divisor bypasses CALC and finishes with
// the same latency as a divide-by-zero. Results are the same either way.
module sm_div_seq #(
  parameter int DW_MAG = 4,
  parameter int DV_MAG = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sm_div_seq_if.slave bus
);

  // Iteration counter must be able to hold DW_MAG-1.
  localparam int CW = (DW_MAG > 1) ? $clog2(DW_MAG) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Control state
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Latched operands; dvd_q doubles as the quotient shift register: dividend
  // bits leave at the top while quotient bits enter at the bottom.
  logic              a_sign_q, a_sign_d;
  logic              b_sign_q, b_sign_d;
  logic [DW_MAG-1:0] dvd_q, dvd_d;
  logic [DV_MAG-1:0] dvs_q, dvs_d;
  logic [DV_MAG:0]   rem_q, rem_d;

  // Registered results
  logic              done_q, done_d;
  logic [DW_MAG:0]   q_q, q_d;
  logic [DV_MAG:0]   r_q, r_d;
  logic              z_q, z_d;
  logic              dz_q, dz_d;

  // Datapath for one restoring step
  logic [DV_MAG:0]   shifted;
  logic [DV_MAG+1:0] trial;
  logic              q_bit;
  logic [DV_MAG:0]   rem_next;
  logic [DW_MAG-1:0] q_mag;
  logic [DV_MAG-1:0] r_mag;
  logic              last_iter;
  logic              a_mag_zero;
  logic              b_mag_zero;

  // One restoring iteration: shift in the next dividend bit, trial-subtract
  // the divisor and keep the difference only if it did not go negative.
  always_comb begin
    shifted   = {rem_q[DV_MAG-1:0], dvd_q[DW_MAG-1]};
    trial     = {1'b0, shifted} - {2'b00, dvs_q};
    q_bit     = ~trial[DV_MAG+1];
    rem_next  = q_bit ? trial[DV_MAG:0] : shifted;
    // The partial remainder is always below the divisor, so its top bit is
    // zero after a completed step and the low DV_MAG bits carry the value.
    q_mag     = {dvd_q[DW_MAG-2:0], q_bit};
    r_mag     = rem_next[DV_MAG-1:0];
    last_iter = (cnt_q == CW'(DW_MAG - 1));
    a_mag_zero = (bus.i_A[DW_MAG-1:0] == '0);
    b_mag_zero = (bus.i_B[DV_MAG-1:0] == '0);
  end

  // Next-state and result logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    q_d      = q_q;
    r_d      = r_q;
    z_d      = z_q;
    dz_d     = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          // Capture operands and clear previous results on acceptance.
          a_sign_d = bus.i_A[DW_MAG];
          b_sign_d = bus.i_B[DV_MAG];
          dvd_d    = bus.i_A[DW_MAG-1:0];
          dvs_d    = bus.i_B[DV_MAG-1:0];
          rem_d    = '0;
          cnt_d    = '0;
          q_d      = '0;
          r_d      = '0;
          z_d      = 1'b0;
          dz_d     = 1'b0;
          if (b_mag_zero) begin
            // Divide-by-zero finishes immediately with a zero quotient.
            state_d = ST_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            z_d     = 1'b1;
`ifdef SM_DIV_EARLY_ZERO_EN
          end else if (a_mag_zero) begin
            // Zero dividend: the answer is known without iterating.
            state_d = ST_DONE;
            done_d  = 1'b1;
            z_d     = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
`else
          end else begin
            // A zero dividend simply runs the full iteration count.
            state_d = ST_CALC;
          end
`endif
        end
      end

      ST_CALC: begin
        dvd_d = q_mag;
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          // Final step: publish results, suppressing negative zero.
          state_d = ST_DONE;
          done_d  = 1'b1;
          q_d     = {(a_sign_q ^ b_sign_q) & (q_mag != '0), q_mag};
          r_d     = {a_sign_q & (r_mag != '0), r_mag};
          z_d     = (q_mag == '0);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any division in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      q_q      <= '0;
      r_q      <= '0;
      z_q      <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      q_q      <= q_d;
      r_q      <= r_d;
      z_q      <= z_d;
      dz_q     <= dz_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.o_busy = (state_q != ST_IDLE);
    bus.o_done = done_q;
    bus.o_Q    = q_q;
    bus.o_R    = r_q;
    bus.o_Z    = z_q;
    bus.o_DZ   = dz_q;
  end

endmodule

// File: tb/tb_sm_div_seq.sv
// tb_sm_div_seq: scoreboard bench for sm_div_seq (defaults DW_MAG=4, DV_MAG=2).
module tb_sm_div_seq;

  logic clk;
  logic rst_n;

  sm_div_seq_if #(.DW_MAG(4), .DV_MAG(2)) bus ();

  sm_div_seq #(.DW_MAG(4), .DV_MAG(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] q;
    logic [2:0] r;
    logic       z;
    logic       dz;
    logic [7:0] lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model built from integer divide/modulo.
  function automatic exp_t model(input logic [4:0] a, input logic [2:0] b);
    exp_t e;
    logic [3:0] am;
    logic [1:0] bm;
    logic [3:0] qm;
    logic [3:0] rm;
    am = a[3:0];
    bm = b[1:0];
    if (bm == 2'd0) begin
      e.q = 5'd0; e.r = 3'd0; e.z = 1'b1; e.dz = 1'b1; e.lat = 8'd0;
    end else begin
      qm = am / {2'b00, bm};
      rm = am % {2'b00, bm};
      e.q  = {(a[4] ^ b[2]) && (qm != 4'd0), qm};
      e.r  = {a[4] && (rm != 4'd0), rm[1:0]};
      e.z  = (qm == 4'd0);
      e.dz = 1'b0;
`ifdef SM_DIV_EARLY_ZERO_EN
      e.lat = (am == 4'd0) ? 8'd0 : 8'd4;
`else
      e.lat = 8'd4;
`endif
    end
    return e;
  endfunction

  // One division: push expectation, pulse start, wait for done, pop and compare.
  // With poke set, a second start with different operands is driven mid-CALC.
  task automatic run_div(input logic [4:0] a, input logic [2:0] b, input bit poke);
    exp_t e;
    int   lat;
    sb_q.push_back(model(a, b));
    bus.i_start = 1'b1;
    bus.i_A     = a;
    bus.i_B     = b;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1)
      $display("FAIL busy_after_start: got %b want 1", bus.o_busy);
    else passed++;
    lat = 0;
    while (bus.o_done !== 1'b1 && lat < 20) begin
      if (lat == 0) begin
        // Previous results must have been cleared by acceptance.
        checks++;
        if (bus.o_Q !== 5'd0 || bus.o_DZ !== 1'b0)
          $display("FAIL clear_on_start: Q=%b DZ=%b want 00000/0", bus.o_Q, bus.o_DZ);
        else passed++;
      end
      if (poke && lat == 1) begin
        bus.i_start = 1'b1;
        bus.i_A     = 5'b0_0011;
        bus.i_B     = 3'b0_11;
      end
      if (poke && lat == 2) bus.i_start = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.i_start = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (bus.o_done !== 1'b1) begin
      $display("FAIL done_timeout: no o_done within %0d cycles", lat);
      return;
    end else passed++;
    $display("div A=%b B=%b -> Q=%b R=%b Z=%b DZ=%b lat=%0d", a, b,
             bus.o_Q, bus.o_R, bus.o_Z, bus.o_DZ, lat);
    checks++;
    if (lat !== int'(e.lat)) $display("FAIL latency: got %0d want %0d", lat, e.lat);
    else passed++;
    checks++;
    if (bus.o_Q !== e.q) $display("FAIL quotient: got %b want %b", bus.o_Q, e.q);
    else passed++;
    checks++;
    if (bus.o_R !== e.r) $display("FAIL remainder: got %b want %b", bus.o_R, e.r);
    else passed++;
    checks++;
    if (bus.o_Z !== e.z || bus.o_DZ !== e.dz)
      $display("FAIL flags: got Z=%b DZ=%b want Z=%b DZ=%b", bus.o_Z, bus.o_DZ, e.z, e.dz);
    else passed++;
    // Next cycle: back to IDLE, pulse ended, results held.
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_Q !== e.q || bus.o_R !== e.r)
      $display("FAIL post_done: busy=%b done=%b Q=%b R=%b want 0/0/%b/%b",
               bus.o_busy, bus.o_done, bus.o_Q, bus.o_R, e.q, e.r);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_A     = '0;
    bus.i_B     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_Q, bus.o_R, bus.o_Z, bus.o_DZ} !== 12'd0)
      $display("FAIL reset_state: busy=%b done=%b Q=%b R=%b Z=%b DZ=%b want all 0",
               bus.o_busy, bus.o_done, bus.o_Q, bus.o_R, bus.o_Z, bus.o_DZ);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_basic();
    run_div(5'b0_1001, 3'b0_10, 1'b0);   // +9 / +2
    run_div(5'b1_0111, 3'b0_11, 1'b0);   // -7 / +3
    run_div(5'b1_0010, 3'b1_11, 1'b0);   // -2 / -3
  endtask

  task automatic test_div_by_zero();
    run_div(5'b0_1101, 3'b1_00, 1'b0);
    run_div(5'b1_0110, 3'b0_00, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_div(5'b0_1111, 3'b0_01, 1'b1);   // mid-CALC restart ignored
    run_div(5'b0_0000, 3'b0_11, 1'b0);   // zero dividend latency
    run_div(5'b1_0000, 3'b1_10, 1'b0);   // negative zero suppressed
  endtask

  task automatic test_reset_abort();
    bus.i_start = 1'b1;
    bus.i_A     = 5'b0_1001;
    bus.i_B     = 3'b0_10;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_Q, bus.o_R, bus.o_Z, bus.o_DZ} !== 12'd0)
      $display("FAIL abort_outputs: busy=%b done=%b Q=%b R=%b Z=%b DZ=%b want all 0",
               bus.o_busy, bus.o_done, bus.o_Q, bus.o_R, bus.o_Z, bus.o_DZ);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", bus.o_done);
      else passed++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("abort done, reset released");
    run_div(5'b0_1001, 3'b0_10, 1'b0);
  endtask

  task automatic test_random();
    logic [4:0] a;
    logic [2:0] b;
    for (int i = 0; i < 10; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 3'($urandom_range(0, 7));
      run_div(a, b, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sm_div_seq.md
# sm_div_seq

Sequential sign-magnitude divider, the inverse of the datapath's combinational 3-bit multiplier. It takes a 5-bit sign-magnitude dividend in the multiplier's product format and a 3-bit sign-magnitude divisor in its operand format. It produces quotient, remainder, zero and divide-by-zero flags with a restoring algorithm, one quotient bit per clock. A start/busy/done handshake connects it to the arithmetic-unit controller.

## Interface
Parameters:
- `DW_MAG`, default 4: dividend and quotient magnitude width; also the iteration count.
- `DV_MAG`, default 2: divisor and remainder magnitude width.

Ports:
- `i_clk`, input, 1: clock; all state updates on the rising edge.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_start`, input, 1: request a division; sampled only in IDLE.
- `i_A`, input, DW_MAG+1: dividend; MSB is the sign (1 = negative), the rest is the magnitude.
- `i_B`, input, DV_MAG+1: divisor; MSB is the sign, the rest is the magnitude.
- `o_busy`, output, 1: high whenever the state is not IDLE.
- `o_done`, output, 1: one-cycle pulse; the results are valid from this cycle onward.
- `o_Q`, output, DW_MAG+1: quotient, sign-magnitude.
- `o_R`, output, DV_MAG+1: remainder, sign-magnitude.
- `o_Z`, output, 1: high when the quotient magnitude is 0.
- `o_DZ`, output, 1: high when the divisor magnitude is 0.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE goes to CALC on `i_start`.
  - IDLE goes straight to DONE on `i_start` when the divisor magnitude is 0.
  - CALC goes to DONE after DW_MAG iterations.
  - DONE goes to IDLE unconditionally.
- On start acceptance:
  - Latch the dividend magnitude, the divisor magnitude, and both signs.
  - Clear the partial remainder (DV_MAG+1 bits) and the iteration counter.
- Each CALC cycle:
  - Shift the next dividend MSB into the partial remainder.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative: keep it and set the quotient bit to 1.
  - Otherwise: restore the partial remainder and set the quotient bit to 0.
- Result sign and flag rules:
  - Quotient sign = XOR of the two operand signs.
  - Remainder sign = dividend sign.
  - Either sign is forced to 0 when its magnitude is 0; negative zero is never produced.
  - `o_Z` = (quotient magnitude == 0).
- Divide-by-zero: `o_DZ`=1, `o_Q`=0, `o_R`=0, `o_Z`=1.
- Outputs are registered. They update only on entry to DONE and hold until the next accepted start.
- On the next accepted start, the outputs clear and `o_DZ` drops.
- `i_start` in CALC or DONE is ignored; no queueing.
- Operand changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, `o_busy`=0, `o_done`=0, `o_Q`=0, `o_R`=0, `o_Z`=0, `o_DZ`=0.
- Normal latency, with start sampled at edge 0:
  - CALC iterations on edges 1..DW_MAG.
  - `o_done` high for the cycle after edge DW_MAG, which is edge 4 with the defaults.
  - Back in IDLE after edge DW_MAG+1; a new start is accepted at that edge or later.
- Divide-by-zero latency: `o_done` high for the cycle after edge 0.
- `o_busy` rises after the accepting edge and falls after the edge leaving DONE.
- Asserting `i_rst_n` low mid-operation immediately returns every output to its reset value. No `o_done` is produced for the aborted operation.

## Configuration
- `SM_DIV_EARLY_ZERO_EN` defined:
  - A dividend magnitude of 0 with a non-zero divisor skips CALC and goes straight to DONE (same latency as divide-by-zero).
  - Results: `o_Q`=0, `o_R`=0, `o_Z`=1.
- Not defined: a zero dividend runs the full DW_MAG iterations. Results are identical; only the latency differs.
- Divide-by-zero handling is unaffected by the macro.

## Test plan
- `i_A`=0_1001 (+9), `i_B`=0_10 (+2), start pulse -> `o_done` after edge 4; `o_Q`=0_0100, `o_R`=0_01, `o_Z`=0, `o_DZ`=0.
- `i_A`=1_0111 (−7), `i_B`=0_11 (+3) -> `o_Q`=1_0010, `o_R`=1_01.
- `i_A`=1_0010 (−2), `i_B`=1_11 (−3) -> `o_Q`=0_0000, `o_Z`=1, `o_R`=1_10.
- `i_B`=1_00, any `i_A` -> `o_done` the cycle after the start edge; `o_DZ`=1, `o_Q`=0, `o_R`=0, `o_Z`=1.
- `i_A`=0_1111, `i_B`=0_01; re-pulse `i_start` with changed operands during CALC -> the extra start is ignored; `o_Q`=0_1111, `o_R`=0_00. Then immediately start `i_A`=0_0000, `i_B`=0_11 -> done after 1 cycle with the macro defined, after 5 cycles without.
- Start `i_A`=0_1001, `i_B`=0_10; pull `i_rst_n` low after edge 2 -> all outputs 0 at once, no `o_done`; after release, a new division completes normally.
